// File: rtl/hs32_sram.sv
// hs32_sram: 32-bit request port to a 16-bit asynchronous SRAM.
// Each request becomes two half-word accesses: LO (bits [15:0]) and then HI (bits [31:16]).
// Every SRAM-facing output and every initiator-facing output is a flop.
// The next value of each output flop is taken from the next state, so the
// strobes line up exactly with the state the FSM is in during that cycle.
module hs32_sram #(
    parameter int unsigned WAIT = 1,   // strobe cycles per half-word, 1..15
    parameter int unsigned AW   = 18   // SRAM half-word address width
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   addr,
    input  logic          rw,
    input  logic [31:0]   dtw,
    input  logic          valid,
    output logic [31:0]   dtr,
    output logic          done,
    output logic [AW-1:0] sram_addr,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic [15:0]   sram_dq_o,
    input  logic [15:0]   sram_dq_i,
    output logic          sram_dq_oe
);

    localparam int unsigned CW = 4;
    localparam int unsigned WW = AW - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   word_q, word_d;
    logic            rw_q, rw_d;
    logic [31:0]     dtw_q, dtw_d;
    logic [15:0]     lo_q, lo_d;
    logic [31:0]     dtr_q, dtr_d;
    logic            done_q, done_d;
    logic [AW-1:0]   sram_addr_q, sram_addr_d;
    logic            ce_n_q, ce_n_d;
    logic            oe_n_q, oe_n_d;
    logic            we_n_q, we_n_d;
    logic [15:0]     dq_o_q, dq_o_d;
    logic            dq_oe_q, dq_oe_d;
    logic            active_d;

    // Byte-lane and aliased upper address bits are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^{addr[31:AW+1], addr[1:0]};

    // Next state, request latch, phase counter and read-data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        rw_d    = rw_q;
        dtw_d   = dtw_q;
        lo_d    = lo_q;
        dtr_d   = dtr_q;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d = LO;
                    cnt_d   = CW'(WAIT);
                    word_d  = addr[AW:2];
                    rw_d    = rw;
                    dtw_d   = dtw;
                end
            end
            LO: begin
                if (cnt_q == CW'(0)) begin
                    state_d = HI;
                    cnt_d   = CW'(WAIT);
                    if (!rw_q) begin
                        lo_d = sram_dq_i;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HI: begin
                if (cnt_q == CW'(0)) begin
                    state_d = DONE;
                    if (!rw_q) begin
                        dtr_d = {sram_dq_i, lo_q};
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output flop inputs, derived from the state the FSM is about to enter.
    always_comb begin
        active_d    = (state_d == LO) || (state_d == HI);
        done_d      = (state_d == DONE);
        ce_n_d      = !active_d;
        oe_n_d      = !(active_d && !rw_d);
        dq_oe_d     = active_d && rw_d;
        // Final cycle of a write phase is a hold cycle with we_n released.
        we_n_d      = !(active_d && rw_d && (cnt_d != CW'(0)));
        sram_addr_d = sram_addr_q;
        dq_o_d      = dq_o_q;
        if (active_d) begin
            sram_addr_d = {word_d, (state_d == HI)};
            dq_o_d      = (state_d == HI) ? dtw_d[31:16] : dtw_d[15:0];
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            rw_q        <= 1'b0;
            dtw_q       <= '0;
            lo_q        <= '0;
            dtr_q       <= '0;
            done_q      <= 1'b0;
            sram_addr_q <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dq_o_q      <= '0;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            rw_q        <= rw_d;
            dtw_q       <= dtw_d;
            lo_q        <= lo_d;
            dtr_q       <= dtr_d;
            done_q      <= done_d;
            sram_addr_q <= sram_addr_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    assign dtr        = dtr_q;
    assign done       = done_q;
    assign sram_addr  = sram_addr_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;

endmodule

// File: tb/tb_hs32_sram.sv
// Bench for hs32_sram: lane 0 runs WAIT=1, lane 1 runs WAIT=3, each with its own SRAM.
module tb_hs32_sram;

    logic        clk;
    logic        rst_n  [2];
    logic [31:0] addr   [2];
    logic        rw     [2];
    logic [31:0] dtw    [2];
    logic        valid  [2];
    logic [31:0] dtr    [2];
    logic        done   [2];
    logic [17:0] s_addr [2];
    logic        ce_n   [2];
    logic        oe_n   [2];
    logic        we_n   [2];
    logic [15:0] dq_o   [2];
    logic [15:0] dq_i   [2];
    logic        dq_oe  [2];

    int vectors;
    int miscompares;
    int cyc;

    for (genvar g = 0; g < 2; g++) begin : lane
        hs32_sram #(.WAIT((g == 0) ? 1 : 3), .AW(18)) u_dut (
            .clk(clk), .reset(rst_n[g]), .addr(addr[g]), .rw(rw[g]), .dtw(dtw[g]),
            .valid(valid[g]), .dtr(dtr[g]), .done(done[g]), .sram_addr(s_addr[g]),
            .sram_ce_n(ce_n[g]), .sram_oe_n(oe_n[g]), .sram_we_n(we_n[g]),
            .sram_dq_o(dq_o[g]), .sram_dq_i(dq_i[g]), .sram_dq_oe(dq_oe[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wt(input int l);
        return (l == 0) ? 1 : 3;
    endfunction

    // Physical SRAMs (1K half-words each), written on the strobes.
    bit [15:0] smem [2][1024];
    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (!ce_n[l] && !we_n[l] && dq_oe[l]) smem[l][s_addr[l][9:0]] <= dq_o[l];
        end
    end
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            dq_i[l] = oe_n[l] ? 16'h0000 : smem[l][s_addr[l][9:0]];
        end
    end

    // Transaction-level model: t = cycles since latch (-1 when idle).
    int        t      [2];
    bit        mw     [2];
    bit [16:0] mword  [2];
    bit [31:0] mdat   [2];
    bit [31:0] mdtr   [2];
    bit        armed  [2];
    bit        rst_seen [2];
    bit [31:0] mmem   [2][256];
    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (!rst_n[l]) begin
                t[l] <= -1; mdtr[l] <= 32'h0; armed[l] <= 1'b1; rst_seen[l] <= 1'b1;
            end else if (t[l] == -1) begin
                if (valid[l]) begin
                    t[l] <= 1; mw[l] <= rw[l]; mword[l] <= addr[l][18:2];
                    mdat[l] <= dtw[l]; rst_seen[l] <= 1'b0;
                end
            end else if (t[l] == 2 * wt(l) + 3) begin
                t[l] <= -1;
            end else begin
                t[l] <= t[l] + 1;
                if (t[l] == 2 * wt(l) + 2) begin
                    if (mw[l]) mmem[l][mword[l][7:0]] <= mdat[l];
                    else       mdtr[l] <= mmem[l][mword[l][7:0]];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    task automatic chkb(input string nm, input logic a, input logic e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    // Advance one cycle and compare both lanes against the model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int l = 0; l < 2; l++) begin
            if (armed[l]) begin
                int w  = wt(l);
                int tt = t[l];
                bit lo = (tt >= 1) && (tt <= w + 1);
                bit hi = (tt >= w + 2) && (tt <= 2 * w + 2);
                bit act = lo || hi;
                int k  = lo ? tt - 1 : tt - w - 2;
                chkb($sformatf("L%0d ce_n", l), ce_n[l], !act);
                chkb($sformatf("L%0d oe_n", l), oe_n[l], !(act && !mw[l]));
                chkb($sformatf("L%0d dq_oe", l), dq_oe[l], act && mw[l]);
                chkb($sformatf("L%0d we_n", l), we_n[l], !(act && mw[l] && (k < w)));
                chkb($sformatf("L%0d done", l), done[l], tt == 2 * w + 3);
                chk($sformatf("L%0d dtr", l), dtr[l], mdtr[l]);
                chkb($sformatf("L%0d we_oe_excl", l), !we_n[l] && !oe_n[l], 1'b0);
                chkb($sformatf("L%0d oe_drive_excl", l), dq_oe[l] && !oe_n[l], 1'b0);
                if (act) begin
                    chk($sformatf("L%0d sram_addr", l), 32'(s_addr[l]), 32'({mword[l], hi}));
                    if (mw[l])
                        chk($sformatf("L%0d dq_o", l), 32'(dq_o[l]),
                            32'(hi ? mdat[l][31:16] : mdat[l][15:0]));
                end else if (rst_seen[l]) begin
                    chk($sformatf("L%0d rst sram_addr", l), 32'(s_addr[l]), 32'h0);
                    chk($sformatf("L%0d rst dq_o", l), 32'(dq_o[l]), 32'h0);
                end
            end
        end
    endtask

    // Issue one request at the current (idle) negedge and run it to done.
    task automatic xact(input int l, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input bit hold, input int lat, output int done_cyc,
                        output int we_lo, output int oe_lo, output int drv);
        int n = 0;
        we_lo = 0; oe_lo = 0; drv = 0;
        valid[l] = 1'b1; rw[l] = wr; addr[l] = a; dtw[l] = d;
        do begin
            tick();
            n++;
            valid[l] = hold;
            addr[l]  = $urandom;
            dtw[l]   = $urandom;
            rw[l]    = 1'($urandom);
            if (!we_n[l]) we_lo++;
            if (!oe_n[l]) oe_lo++;
            if (dq_oe[l]) drv++;
        end while (!done[l] && n < 40);
        chk($sformatf("L%0d latency", l), 32'(n), 32'(lat));
        done_cyc = cyc;
    endtask

    int dc, wl, ol, dv, wr_done;

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        for (int l = 0; l < 2; l++) begin
            rst_n[l] = 1'b0; valid[l] = 1'b0; rw[l] = 1'b0; addr[l] = 32'h0; dtw[l] = 32'h0;
        end
        tick(); tick();
        chkb("rst ce_n", ce_n[0], 1'b1);
        chkb("rst done", done[1], 1'b0);
        chk("rst dtr", dtr[0], 32'h0);
        chk("rst sram_addr", 32'(s_addr[1]), 32'h0);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        tick();

        // WAIT=1 write, valid held until the cycle after done.
        xact(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 5, dc, wl, ol, dv);
        chk("w1 we_n low cycles", 32'(wl), 32'd2);
        chk("w1 dtr unchanged", dtr[0], 32'h0);
        tick();
        valid[0] = 1'b0;
        chk("w1 sram[8]", 32'(smem[0][8]), 32'h0000_BEEF);
        chk("w1 sram[9]", 32'(smem[0][9]), 32'h0000_DEAD);
        tick();

        // WAIT=1 read of the same word.
        xact(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 5, dc, wl, ol, dv);
        chk("r1 dtr", dtr[0], 32'hDEAD_BEEF);
        chk("r1 model dtr", mdtr[0], 32'hDEAD_BEEF);
        chk("r1 dq_oe cycles", 32'(dv), 32'd0);
        chk("r1 oe_n low cycles", 32'(ol), 32'd4);
        tick(); tick();

        // Back-to-back write then read with no extra idle cycle.
        xact(0, 1'b1, 32'h0000_0004, 32'h0000_AAAA, 1'b0, 5, wr_done, wl, ol, dv);
        tick();
        xact(0, 1'b0, 32'h0000_0004, 32'h0, 1'b0, 5, dc, wl, ol, dv);
        chk("b2b done gap", 32'(dc - wr_done), 32'd6);
        chk("b2b dtr", dtr[0], 32'h0000_AAAA);
        chk("b2b sram[2]", 32'(smem[0][2]), 32'h0000_AAAA);
        tick();

        // Reset in cycle 3 of a read; valid held high across reset.
        valid[0] = 1'b1; rw[0] = 1'b0; addr[0] = 32'h0000_0010;
        tick(); valid[0] = 1'b0;
        tick();
        tick(); rst_n[0] = 1'b0; valid[0] = 1'b1;
        tick();
        chkb("abort ce_n", ce_n[0], 1'b1);
        chkb("abort oe_n", oe_n[0], 1'b1);
        chkb("abort we_n", we_n[0], 1'b1);
        chkb("abort done", done[0], 1'b0);
        chk("abort dtr", dtr[0], 32'h0);
        tick();
        chkb("abort ce_n hold", ce_n[0], 1'b1);
        rst_n[0] = 1'b1;
        xact(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 5, dc, wl, ol, dv);
        chk("post-reset dtr", dtr[0], 32'hDEAD_BEEF);
        tick(); tick();

        // WAIT=3 write and read through an aliased address.
        xact(1, 1'b1, 32'h0010_0010, 32'h1234_5678, 1'b0, 9, dc, wl, ol, dv);
        chk("w3 we_n low cycles", 32'(wl), 32'd6);
        tick();
        chk("w3 sram[8]", 32'(smem[1][8]), 32'h0000_5678);
        chk("w3 sram[9]", 32'(smem[1][9]), 32'h0000_1234);
        xact(1, 1'b0, 32'h0010_0010, 32'h0, 1'b0, 9, dc, wl, ol, dv);
        chk("r3 dtr", dtr[1], 32'h1234_5678);
        chk("r3 oe_n low cycles", 32'(ol), 32'd8);
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
